dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (1024x32, synchronous read, active-high enable/write-enable) among three requesters: pipeline MEM stage (P), bench/boot data loader (L), and debug/test port (D).
- Replaces the static priority mux in front of the data memory with a registered arbiter. It provides per-requester grants, read-data return routing, starvation protection and a loader burst lock.
- Sits between the MEM stage and the data memory instance; stalls the pipeline via P_GNT.

Parameters:
ADDR_W, 10, memory address width
DATA_W, 32, memory data width
STARVE_MAX, 8, consecutive denied cycles of a pending L/D request before forced grant (range 1..255)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous reset, active-high
P_REQ/L_REQ/D_REQ  in  1 each  access request from P/L/D
P_WE/L_WE/D_WE  in  1 each  1 = write, 0 = read
P_ADDR/L_ADDR/D_ADDR  in  ADDR_W each  word address
P_WDATA/L_WDATA/D_WDATA  in  DATA_W each  write data
L_LOCK  in  1  loader requests burst ownership
P_GNT/L_GNT/D_GNT  out  1 each  combinational grant; access accepted when REQ & GNT
P_RVALID/L_RVALID/D_RVALID  out  1 each  read data valid, one cycle after granted read
RDATA  out  DATA_W  memory read data, passthrough of MEM_DOUT
MEM_EN  out  1  memory enable, active-high
MEM_WE  out  1  memory write enable, active-high
MEM_ADDR  out  ADDR_W  memory address
MEM_DIN  out  DATA_W  memory write data
MEM_DOUT  in  DATA_W  memory read data (valid one cycle after read enable)
ARB_STATE  out  2  current state (00 NORMAL, 01 FORCE, 10 BURST)

Behaviour:
- Reset (RST=1 at edge): state NORMAL, starvation counter 0, round-robin pointer favours L, all RVALID 0. Outputs combinational: no grant while RST=1; MEM_EN=0.
- At most one GNT per cycle. GNT is only asserted for a requester with REQ=1.
- Winner drives MEM_EN=1, MEM_WE=its WE, MEM_ADDR, MEM_DIN. With no winner: MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_DIN=0.
- NORMAL: P beats L and D. Between L and D, round-robin: pointer flips to the other after each L or D grant.
- Starvation counter: increments (saturating at STARVE_MAX) each cycle with (L_REQ|D_REQ) & no L/D grant; clears on any L/D grant or when L_REQ=D_REQ=0.
- NORMAL->FORCE when counter==STARVE_MAX at a clock edge. In FORCE: P_GNT=0 and round-robin L/D wins. FORCE->NORMAL after that grant, or if L_REQ=D_REQ=0.
- BURST entry: L granted with L_LOCK=1 (from NORMAL or FORCE) -> BURST next cycle. In BURST, only L may be granted; P and D are held off and the counter is frozen. BURST->NORMAL at the first edge where L_LOCK=0 (a granted L access in that cycle still completes).
- Read return: on a granted read (WE=0), register the owner tag. Next cycle assert that owner's RVALID for exactly one cycle. RDATA=MEM_DOUT. Back-to-back reads give back-to-back RVALID, possibly to different owners.
- Writes produce no RVALID.
- RST mid-burst or mid-read: the pending RVALID is dropped, state returns to NORMAL, and the lock is released.
- Simultaneous events: starvation threshold reached while in BURST is ignored until BURST exits. P_REQ deasserting in the same cycle as FORCE entry has no effect on FORCE.

Test Plan:
- Reset: hold RST=1 two cycles with all REQ=1 -> all GNT=0, MEM_EN=0, RVALID=0, ARB_STATE=00.
- Priority/latency: P read addr 0x038 and L read same cycle -> P_GNT=1, L_GNT=0, MEM_ADDR=0x038. Next cycle P_RVALID=1, RDATA = stored 0x00000002.
- Round-robin: P idle, L_REQ=D_REQ=1 continuously -> grants alternate L,D,L,D starting with L after reset.
- Starvation: STARVE_MAX=8, P_REQ=1 continuously, D_REQ=1 -> D denied 8 cycles, cycle 9 ARB_STATE=01, D_GNT=1, P_GNT=0. Following cycle back to P.
- Burst: L writes 0x1..0x4 to addr 0x000..0x003 with L_LOCK=1 while P_REQ=D_REQ=1 -> only L_GNT for 4 cycles. Drop L_LOCK, then P granted. Readback via P returns 0x1..0x4.
- Reset mid-read: L read granted, RST=1 next edge -> L_RVALID stays 0, ARB_STATE=00.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Registered arbiter sharing the single-port data memory among the pipeline (P),
// the loader (L) and the debug port (D), and routing read data back to the requester.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              P_REQ,
  input  logic              L_REQ,
  input  logic              D_REQ,
  input  logic              P_WE,
  input  logic              L_WE,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] P_ADDR,
  input  logic [ADDR_W-1:0] L_ADDR,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] P_WDATA,
  input  logic [DATA_W-1:0] L_WDATA,
  input  logic [DATA_W-1:0] D_WDATA,
  input  logic              L_LOCK,
  output logic              P_GNT,
  output logic              L_GNT,
  output logic              D_GNT,
  output logic              P_RVALID,
  output logic              L_RVALID,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT,
  output logic [1:0]        ARB_STATE
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FORCE  = 2'b01,
    BURST  = 2'b10
  } state_t;

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  state_t     state, state_nxt;
  logic [7:0] starve, starve_nxt;
  logic       fav_d;       // 0: L wins an L/D tie, 1: D wins
  logic [2:0] gnt;         // {D, L, P}
  logic [2:0] rd_owner;
  logic       l_win, d_win, ld_gnt, ld_req;

  assign ld_req = L_REQ | D_REQ;
  assign l_win  = L_REQ & (~D_REQ | ~fav_d);
  assign d_win  = D_REQ & (~L_REQ |  fav_d);

  always_comb begin
    gnt = 3'b000;
    if (!RST) begin
      case (state)
        NORMAL:  gnt = P_REQ ? 3'b001 : {d_win, l_win, 1'b0};
        FORCE:   gnt = {d_win, l_win, 1'b0};
        BURST:   gnt = {1'b0, L_REQ, 1'b0};
        default: gnt = 3'b000;
      endcase
    end
  end

  assign ld_gnt = gnt[1] | gnt[2];

  // Counter is frozen while the loader owns the memory.
  always_comb begin
    starve_nxt = starve;
    if (state != BURST) begin
      if (ld_gnt || !ld_req)  starve_nxt = 8'd0;
      else if (starve < SMAX) starve_nxt = starve + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= NORMAL;
      starve   <= 8'd0;
      fav_d    <= 1'b0;
      rd_owner <= 3'b000;
    end else begin
      state    <= state_nxt;
      starve   <= starve_nxt;
      fav_d    <= gnt[1] ? 1'b1 : (gnt[2] ? 1'b0 : fav_d);
      rd_owner <= gnt & {3{~MEM_WE}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL: begin
        if (gnt[1] && L_LOCK)        state_nxt = BURST;
        else if (starve_nxt == SMAX) state_nxt = FORCE;
      end
      FORCE: begin
        if (gnt[1] && L_LOCK)        state_nxt = BURST;
        else if (ld_gnt || !ld_req)  state_nxt = NORMAL;
      end
      BURST: begin
        if (!L_LOCK)                 state_nxt = NORMAL;
      end
      default:                       state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    MEM_WE   = 1'b0;
    MEM_ADDR = '0;
    MEM_DIN  = '0;
    if (gnt[0]) begin
      MEM_WE = P_WE; MEM_ADDR = P_ADDR; MEM_DIN = P_WDATA;
    end else if (gnt[1]) begin
      MEM_WE = L_WE; MEM_ADDR = L_ADDR; MEM_DIN = L_WDATA;
    end else if (gnt[2]) begin
      MEM_WE = D_WE; MEM_ADDR = D_ADDR; MEM_DIN = D_WDATA;
    end
  end

  assign MEM_EN    = |gnt;
  assign P_GNT     = gnt[0];
  assign L_GNT     = gnt[1];
  assign D_GNT     = gnt[2];
  assign P_RVALID  = rd_owner[0];
  assign L_RVALID  = rd_owner[1];
  assign D_RVALID  = rd_owner[2];
  assign RDATA     = MEM_DOUT;
  assign ARB_STATE = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of the arbitration rules and a shadow memory.
module tb_dmem_port_arbiter;
  localparam int AW = 10, DW = 32, SMAX = 8;

  logic          CLK = 1'b0, RST;
  logic          P_REQ, L_REQ, D_REQ, P_WE, L_WE, D_WE, L_LOCK;
  logic [AW-1:0] P_ADDR, L_ADDR, D_ADDR, MEM_ADDR;
  logic [DW-1:0] P_WDATA, L_WDATA, D_WDATA, RDATA, MEM_DIN, MEM_DOUT;
  logic          P_GNT, L_GNT, D_GNT, P_RVALID, L_RVALID, D_RVALID, MEM_EN, MEM_WE;
  logic [1:0]    ARB_STATE;

  always #5 CLK = ~CLK;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .P_REQ(P_REQ), .L_REQ(L_REQ), .D_REQ(D_REQ),
    .P_WE(P_WE), .L_WE(L_WE), .D_WE(D_WE),
    .P_ADDR(P_ADDR), .L_ADDR(L_ADDR), .D_ADDR(D_ADDR),
    .P_WDATA(P_WDATA), .L_WDATA(L_WDATA), .D_WDATA(D_WDATA),
    .L_LOCK(L_LOCK),
    .P_GNT(P_GNT), .L_GNT(L_GNT), .D_GNT(D_GNT),
    .P_RVALID(P_RVALID), .L_RVALID(L_RVALID), .D_RVALID(D_RVALID),
    .RDATA(RDATA), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT),
    .ARB_STATE(ARB_STATE)
  );

  // Memory the DUT talks to
  logic [DW-1:0] mem [0:1023];
  always @(posedge CLK)
    if (MEM_EN) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
      else        MEM_DOUT <= mem[MEM_ADDR];
    end

  // Reference model: mode 0 normal, 1 forced L/D turn, 2 loader burst.
  // m_win: -1 nobody, 0 P, 1 L, 2 D.
  logic [DW-1:0] ref_mem [0:1023];
  int            m_mode, m_starve, m_win, m_pend;
  bit            m_fav_l;
  logic [DW-1:0] m_pend_data;
  int            n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick_ld();
    if (L_REQ && D_REQ) return m_fav_l ? 1 : 2;
    if (L_REQ) return 1;
    if (D_REQ) return 2;
    return -1;
  endfunction

  task automatic winner(output logic we, output logic [AW-1:0] a, output logic [DW-1:0] d);
    we = 1'b0; a = '0; d = '0;
    case (m_win)
      0: begin we = P_WE; a = P_ADDR; d = P_WDATA; end
      1: begin we = L_WE; a = L_ADDR; d = L_WDATA; end
      2: begin we = D_WE; a = D_ADDR; d = D_WDATA; end
      default: ;
    endcase
  endtask

  task automatic settle();
    logic we; logic [AW-1:0] a; logic [DW-1:0] d;
    #1;
    m_win = -1;
    if (!RST) begin
      if (m_mode == 2)      m_win = L_REQ ? 1 : -1;
      else if (m_mode == 1) m_win = pick_ld();
      else                  m_win = P_REQ ? 0 : pick_ld();
    end
    winner(we, a, d);
    chk("P_GNT", 64'(P_GNT), 64'(m_win == 0));
    chk("L_GNT", 64'(L_GNT), 64'(m_win == 1));
    chk("D_GNT", 64'(D_GNT), 64'(m_win == 2));
    chk("MEM_EN", 64'(MEM_EN), 64'(m_win >= 0));
    chk("MEM_WE", 64'(MEM_WE), 64'(we));
    chk("MEM_ADDR", 64'(MEM_ADDR), 64'(a));
    chk("MEM_DIN", 64'(MEM_DIN), 64'(d));
    chk("P_RVALID", 64'(P_RVALID), 64'(m_pend == 0));
    chk("L_RVALID", 64'(L_RVALID), 64'(m_pend == 1));
    chk("D_RVALID", 64'(D_RVALID), 64'(m_pend == 2));
    chk("ARB_STATE", 64'(ARB_STATE), 64'(m_mode));
    if (m_pend >= 0) chk("RDATA", 64'(RDATA), 64'(m_pend_data));
  endtask

  task automatic tick();
    logic we; logic [AW-1:0] a; logic [DW-1:0] d; bit ld;
    @(posedge CLK);
    if (RST) begin
      m_mode = 0; m_starve = 0; m_fav_l = 1'b1; m_pend = -1;
    end else begin
      winner(we, a, d);
      ld = (m_win == 1) || (m_win == 2);
      if (m_win >= 0 && !we) begin m_pend = m_win; m_pend_data = ref_mem[a]; end
      else m_pend = -1;
      if (m_win >= 0 && we) ref_mem[a] = d;
      if (ld) m_fav_l = (m_win == 2);
      if (m_mode != 2) begin
        if (ld || !(L_REQ || D_REQ)) m_starve = 0;
        else if (m_starve < SMAX)    m_starve++;
      end
      if (m_mode == 2)                 begin if (!L_LOCK) m_mode = 0; end
      else if (m_win == 1 && L_LOCK)   m_mode = 2;
      else if (m_mode == 1)            m_mode = 0;
      else if (m_starve == SMAX)       m_mode = 1;
    end
    @(negedge CLK);
  endtask

  task automatic cyc(); settle(); tick(); endtask

  task automatic idle();
    RST = 1'b0; L_LOCK = 1'b0;
    P_REQ = 1'b0; L_REQ = 1'b0; D_REQ = 1'b0;
    P_WE = 1'b0; L_WE = 1'b0; D_WE = 1'b0;
    P_ADDR = '0; L_ADDR = '0; D_ADDR = '0;
    P_WDATA = '0; L_WDATA = '0; D_WDATA = '0;
  endtask

  task automatic do_reset(); idle(); RST = 1'b1; cyc(); RST = 1'b0; endtask

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hA5A5_0000 ^ 32'(i);
      ref_mem[i] = mem[i];
    end
    mem[10'h038] = 32'h0000_0002; ref_mem[10'h038] = 32'h0000_0002;
    m_mode = 0; m_starve = 0; m_fav_l = 1'b1; m_pend = -1; m_win = -1;

    // Reset with everybody requesting
    idle(); RST = 1'b1; P_REQ = 1'b1; L_REQ = 1'b1; D_REQ = 1'b1; L_LOCK = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_no_gnt", 64'({P_GNT, L_GNT, D_GNT, MEM_EN}), 64'(0));
      chk("rst_state", 64'(ARB_STATE), 64'(0));
      tick();
    end

    // P beats L; read latency one cycle
    idle(); P_REQ = 1'b1; P_ADDR = 10'h038; L_REQ = 1'b1; L_ADDR = 10'h005;
    settle();
    chk("prio_pgnt", 64'(P_GNT), 64'(1));
    chk("prio_lgnt", 64'(L_GNT), 64'(0));
    chk("prio_addr", 64'(MEM_ADDR), 64'(10'h038));
    tick();
    idle(); settle();
    chk("prio_rvalid", 64'(P_RVALID), 64'(1));
    chk("prio_rdata", 64'(RDATA), 64'(32'h2));
    tick();

    // Round-robin L,D,L,D from reset
    do_reset();
    L_REQ = 1'b1; D_REQ = 1'b1; L_ADDR = 10'h003; D_ADDR = 10'h004;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_l", 64'(L_GNT), 64'(i % 2 == 0));
      chk("rr_d", 64'(D_GNT), 64'(i % 2 == 1));
      tick();
    end

    // Starvation of D under constant P traffic
    do_reset();
    P_REQ = 1'b1; P_ADDR = 10'h010; D_REQ = 1'b1; D_ADDR = 10'h020;
    for (int i = 1; i <= SMAX; i++) begin
      settle();
      chk("starve_denied", 64'({P_GNT, D_GNT}), 64'(2'b10));
      tick();
    end
    settle();
    chk("force_state", 64'(ARB_STATE), 64'(2'b01));
    chk("force_gnt", 64'({P_GNT, D_GNT}), 64'(2'b01));
    tick();
    settle();
    chk("force_exit", 64'({ARB_STATE, P_GNT}), 64'(3'b001));
    tick();

    // Loader burst writes while P and D wait
    do_reset();
    L_REQ = 1'b1; L_WE = 1'b1; L_LOCK = 1'b1; L_ADDR = 10'h000; L_WDATA = 32'h1;
    cyc();
    P_REQ = 1'b1; P_ADDR = 10'h100; D_REQ = 1'b1; D_ADDR = 10'h101;
    for (int i = 1; i < 4; i++) begin
      L_ADDR = AW'(i); L_WDATA = 32'(i + 1);
      settle();
      chk("burst_only_l", 64'({P_GNT, L_GNT, D_GNT}), 64'(3'b010));
      chk("burst_state", 64'(ARB_STATE), 64'(2'b10));
      tick();
    end
    L_REQ = 1'b0; L_LOCK = 1'b0; L_WE = 1'b0;
    settle();
    chk("burst_last", 64'(P_GNT), 64'(0));
    tick();
    D_REQ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      P_REQ = (i < 4); P_ADDR = AW'(i);
      settle();
      if (i < 4) chk("post_burst_pgnt", 64'(P_GNT), 64'(1));
      if (i > 0) chk("readback", 64'(RDATA), 64'(i));
      tick();
    end

    // Reset while a read is in flight and during a burst
    do_reset();
    L_REQ = 1'b1; L_ADDR = 10'h038; L_LOCK = 1'b1;
    cyc();
    RST = 1'b1;
    cyc();
    idle(); settle();
    chk("rst_read_rvalid", 64'(L_RVALID), 64'(0));
    chk("rst_burst_state", 64'(ARB_STATE), 64'(0));
    tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      RST     = ($urandom_range(99) == 0);
      P_REQ   = ($urandom_range(3) != 0);
      L_REQ   = $urandom_range(1) == 1;
      D_REQ   = $urandom_range(1) == 1;
      L_LOCK  = ($urandom_range(2) != 0);
      P_WE    = $urandom_range(1) == 1;
      L_WE    = $urandom_range(1) == 1;
      D_WE    = $urandom_range(1) == 1;
      P_ADDR  = AW'($urandom_range(15));
      L_ADDR  = AW'($urandom_range(15));
      D_ADDR  = AW'($urandom_range(15));
      P_WDATA = $urandom;
      L_WDATA = $urandom;
      D_WDATA = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
